// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int WORD_BYTES = 4;
    localparam int REQ_CPU    = 0;
    localparam int REQ_DBG    = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               last_grant_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_o = '0;
        if (valid_i[REQ_CPU] && valid_i[REQ_DBG]) begin
            grant_o[REQ_CPU] = last_grant_i;
            grant_o[REQ_DBG] = !last_grant_i;
        end else begin
            grant_o = valid_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter/sequencer for the data memory; DMEM_ARB_ADDR_CHECK_EN enables address checking
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 61
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic                  rsp_err,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_write_n,
    output logic                  mem_read_n,
    input  logic [DATA_W-1:0]     mem_rdata
);

    state_t               state_q;
    logic                 last_grant_q;
    logic                 id_q;
    logic                 write_q;
    logic                 err_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [DATA_W-1:0]    mem_wdata_q;
    logic                 mem_write_n_q;
    logic                 mem_read_n_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 rsp_err_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    logic [NUM_REQ-1:0]   grant;
    logic                 gnt_id;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_write;
    logic                 sel_err;

    rr_arb2 u_rr_arb2 (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign gnt_id    = grant[REQ_DBG];
    assign sel_addr  = gnt_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
    assign sel_wdata = gnt_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    assign sel_write = req_write[gnt_id];

`ifdef DMEM_ARB_ADDR_CHECK_EN
    // Whole word must be aligned and fit inside the backing array.
    assign sel_err = (sel_addr[1:0] != 2'b00) ||
                     (sel_addr > ADDR_W'(MEM_BYTES - WORD_BYTES));
`else
    logic unused_mem_bytes;
    assign unused_mem_bytes = (MEM_BYTES != 0);
    assign sel_err = 1'b0;
`endif

    // Ready is withheld during reset so no requester sees a grant that gets discarded.
    assign req_ready = (state_q == ST_IDLE && !Reset) ? grant : '0;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            write_q       <= 1'b0;
            err_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_write_n_q <= 1'b1;
            mem_read_n_q  <= 1'b1;
            rsp_valid_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    if (|req_valid) begin
                        state_q       <= ST_ACCESS;
                        id_q          <= gnt_id;
                        last_grant_q  <= gnt_id;
                        write_q       <= sel_write;
                        err_q         <= sel_err;
                        mem_addr_q    <= sel_addr;
                        mem_wdata_q   <= sel_wdata;
                        mem_write_n_q <= !(sel_write && !sel_err);
                        mem_read_n_q  <= !(!sel_write && !sel_err);
                    end
                end
                ST_ACCESS: begin
                    state_q       <= ST_IDLE;
                    mem_write_n_q <= 1'b1;
                    mem_read_n_q  <= 1'b1;
                    rsp_valid_q   <= req_onehot(id_q);
                    rsp_err_q     <= err_q;
                    if (!write_q) begin
                        rsp_rdata_q <= err_q ? '0 : mem_rdata;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Strobes drop with Reset itself so a write cannot land in the reset cycle.
    assign mem_write_n = mem_write_n_q | Reset;
    assign mem_read_n  = mem_read_n_q | Reset;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with memory model and scoreboard
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MEM_BYTES = 61;
`ifdef DMEM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic                CLK = 1'b0;
    logic                Reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_write;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          rsp_valid;
    logic                rsp_err;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_write_n;
    logic                mem_read_n;
    logic [DATA_W-1:0]   mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BYTES(MEM_BYTES)) dut (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write_n(mem_write_n), .mem_read_n(mem_read_n), .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seed(input int k);
        return 8'(k * 3 + 1);
    endfunction

    function automatic logic exp_err(input logic [31:0] a);
        return CHECK_EN && ((a[1:0] != 2'b00) || (a > 32'd57));
    endfunction

    // Big-endian byte memory driven only by the strobes.
    logic [7:0] bus_mem [MEM_BYTES];
    bit seeded_bus = 1'b0;

    always @(negedge CLK) begin
        if (!seeded_bus) begin
            for (int k = 0; k < MEM_BYTES; k++) bus_mem[k] = seed(k);
            seeded_bus = 1'b1;
        end
        if (mem_write_n === 1'b0) begin
            for (int k = 0; k < 4; k++)
                if (int'(mem_addr) + k < MEM_BYTES)
                    bus_mem[int'(mem_addr) + k] = mem_wdata[31-8*k -: 8];
        end
    end

    always_comb begin
        mem_rdata = '0;
        if (mem_read_n === 1'b0) begin
            for (int k = 0; k < 4; k++)
                if (int'(mem_addr) + k < MEM_BYTES)
                    mem_rdata[31-8*k -: 8] = bus_mem[int'(mem_addr) + k];
        end
    end

    typedef struct {
        int          id;
        logic        wr;
        logic        err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          hs_cyc_q[$];
    int          hs_id_q[$];
    logic [7:0]  gold_mem [MEM_BYTES];
    bit          seeded_gold = 1'b0;
    logic [31:0] last_rdata = '0;
    int          wr_low_cnt = 0;
    int          rd_low_cnt = 0;
    int          err_seen = 0;

    always @(negedge CLK) begin : monitor
        exp_t        e;
        exp_t        acc;
        bit          acc_pend;
        int          id;
        logic [31:0] w;
        if (!seeded_gold) begin
            for (int k = 0; k < MEM_BYTES; k++) gold_mem[k] = seed(k);
            seeded_gold = 1'b1;
            acc_pend = 1'b0;
        end
        if (mem_write_n === 1'b0) wr_low_cnt++;
        if (mem_read_n === 1'b0) rd_low_cnt++;
        if (acc_pend && !Reset) begin
            chk("access_write_n", 32'(mem_write_n), 32'(!(acc.wr && !acc.err)));
            chk("access_read_n", 32'(mem_read_n), 32'(!(!acc.wr && !acc.err)));
            chk("access_addr", mem_addr, acc.addr);
            if (acc.wr) chk("access_wdata", mem_wdata, acc.wdata);
        end else begin
            chk("quiet_write_n", 32'(mem_write_n), 32'd1);
            chk("quiet_read_n", 32'(mem_read_n), 32'd1);
        end
        acc_pend = 1'b0;
        if (Reset) begin
            exp_q.delete();
            last_rdata = '0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(rsp_valid), (e.id == 1) ? 32'd2 : 32'd1);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                if (rsp_err === 1'b1) err_seen++;
                if (e.wr) begin
                    chk("rsp_rdata_hold", rsp_rdata, last_rdata);
                    if (!e.err)
                        for (int k = 0; k < 4; k++) gold_mem[int'(e.addr) + k] = e.wdata[31-8*k -: 8];
                end else begin
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    last_rdata = e.rdata;
                end
            end else begin
                chk("rsp_quiet", 32'(rsp_valid), 32'd0);
            end
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (req_ready != 2'b00) begin
                id = req_ready[1] ? 1 : 0;
                chk("ready_has_valid", 32'(req_valid[id]), 32'd1);
                e.id    = id;
                e.wr    = req_write[id];
                e.addr  = req_addr[id*32 +: 32];
                e.wdata = req_wdata[id*32 +: 32];
                e.err   = exp_err(e.addr);
                w = '0;
                if (!e.err && !e.wr)
                    for (int k = 0; k < 4; k++) w[31-8*k -: 8] = gold_mem[int'(e.addr) + k];
                e.rdata = w;
                e.due   = cyc + 2;
                exp_q.push_back(e);
                acc = e;
                acc_pend = 1'b1;
                hs_cyc_q.push_back(cyc);
                hs_id_q.push_back(id);
            end
        end
    end

    task automatic wait_ready(input int id);
        int n;
        n = 0;
        @(negedge CLK);
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        assert (req_ready[id] === 1'b1) else begin
            errors++;
            $error("FAIL ready_timeout: requester %0d observed ready 0 expected 1", id);
        end
    endtask

    task automatic do_req(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_addr[id*32 +: 32]  = a;
        req_wdata[id*32 +: 32] = d;
        wait_ready(id);
        @(posedge CLK); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        chk("rsp_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic mem_compare(input string tag);
        int nbad;
        nbad = 0;
        for (int k = 0; k < MEM_BYTES; k++) if (bus_mem[k] !== gold_mem[k]) nbad++;
        chk(tag, 32'(nbad), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_write_n"}, 32'(mem_write_n), 32'd1);
        chk({tag, "_read_n"}, 32'(mem_read_n), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1_bytes [4];
        int         exp_ids [4];
        int         wc0;
        int         rc0;
        int         ec0;
        t1_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_ids  = '{0, 1, 0, 1};

        Reset = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("reset");

        // Idle bus
        repeat (5) begin
            @(negedge CLK);
            chk("idle_write_n", 32'(mem_write_n), 32'd1);
            chk("idle_read_n", 32'(mem_read_n), 32'd1);
            chk("idle_ready", 32'(req_ready), 32'd0);
            chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        end

        // Write then read from requester 0
        do_req(0, 1'b1, 32'd8, 32'h1122_3344);
        wait_idle();
        for (int k = 0; k < 4; k++) chk("t1_mem_byte", 32'(bus_mem[8 + k]), 32'(t1_bytes[k]));
        do_req(0, 1'b0, 32'd8, 32'd0);
        wait_idle();
        chk("t1_read_data", rsp_rdata, 32'h1122_3344);
        mem_compare("t1_mem_image");

        // Back-to-back writes from requester 1 with valid held
        @(posedge CLK); #1;
        wc0 = wr_low_cnt;
        hs_cyc_q.delete();
        hs_id_q.delete();
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr[63:32]  = 32'(4 * i);
            req_wdata[63:32] = 32'hA5A5_0000 + 32'(i);
            wait_ready(1);
            @(posedge CLK); #1;
        end
        req_valid[1] = 1'b0;
        wait_idle();
        chk("b2b_grants", 32'(hs_cyc_q.size()), 32'd4);
        for (int i = 1; i < hs_cyc_q.size(); i++)
            chk("b2b_ready_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd2);
        chk("b2b_write_low_cycles", 32'(wr_low_cnt - wc0), 32'd4);
        mem_compare("b2b_mem_image");

        // Contention fairness right after reset
        @(posedge CLK); #1 Reset = 1'b1;
        @(posedge CLK); #1 Reset = 1'b0;
        req_write = 2'b00;
        req_addr  = {32'd4, 32'd0};
        req_valid = 2'b11;
        hs_cyc_q.delete();
        hs_id_q.delete();
        repeat (8) @(negedge CLK);
        @(posedge CLK); #1 req_valid = 2'b00;
        wait_idle();
        chk("fair_grants", 32'(hs_id_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < hs_id_q.size(); i++)
            chk("fair_order", 32'(hs_id_q[i]), 32'(exp_ids[i]));
        for (int i = 1; i < hs_cyc_q.size(); i++)
            chk("fair_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd2);

        // Reset during the ACCESS cycle of a write
        @(posedge CLK); #1;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[31:0]  = 32'd16;
        req_wdata[31:0] = 32'hDEAD_BEEF;
        wait_ready(0);
        @(posedge CLK); #1;
        Reset = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge CLK);
        chk("rst_acc_write_n", 32'(mem_write_n), 32'd1);
        @(posedge CLK); #1 Reset = 1'b0;
        @(negedge CLK);
        chk_reset_outputs("rst_acc");
        for (int k = 16; k < 20; k++) chk("rst_acc_mem_byte", 32'(bus_mem[k]), 32'(seed(k)));
        repeat (2) begin
            @(negedge CLK);
            chk("rst_acc_no_rsp", 32'(rsp_valid), 32'd0);
        end

`ifdef DMEM_ARB_ADDR_CHECK_EN
        // Address check: misaligned read, out-of-range write, then a good read
        wc0 = wr_low_cnt;
        rc0 = rd_low_cnt;
        ec0 = err_seen;
        do_req(0, 1'b0, 32'd6, 32'd0);
        wait_idle();
        chk("chk_bad_read_rdata", rsp_rdata, 32'd0);
        do_req(1, 1'b1, 32'd60, 32'h0BAD_0BAD);
        wait_idle();
        chk("chk_bad_errors", 32'(err_seen - ec0), 32'd2);
        chk("chk_bad_no_write", 32'(wr_low_cnt - wc0), 32'd0);
        chk("chk_bad_no_read", 32'(rd_low_cnt - rc0), 32'd0);
        do_req(0, 1'b0, 32'd4, 32'd0);
        wait_idle();
        chk("chk_good_errors", 32'(err_seen - ec0), 32'd2);
        chk("chk_good_read", 32'(rd_low_cnt - rc0), 32'd1);
        chk("chk_good_rdata", rsp_rdata, 32'hA5A5_0001);
        mem_compare("chk_mem_image");
`else
        wc0 = wr_low_cnt;
        rc0 = rd_low_cnt;
        ec0 = err_seen;
        do_req(0, 1'b0, 32'd6, 32'd0);
        wait_idle();
        chk("nochk_unaligned_read", 32'(rd_low_cnt - rc0), 32'd1);
        chk("nochk_no_err", 32'(err_seen - ec0), 32'd0);
        chk("nochk_no_write", 32'(wr_low_cnt - wc0), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the word-wide, byte-addressed, big-endian data memory.
- Requester 0 is the CPU MEM stage; requester 1 is the debug/DMA loader.
- Converts valid/ready requests into the memory's active-low MemWrite/MemRead strobes, one transaction at a time.
- Returns a registered response pulse to the owning requester.

Parameters:
- ADDR_W, 32, request/memory address width.
- DATA_W, 32, data width; fixed word size of 4 bytes.
- MEM_BYTES, 61, size of the backing byte array; used only by the optional check.

Ports:
- CLK  in  1  clock; memory writes on negedge of the same clock.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_write  in  2  1 = write, 0 = read.
- req_addr  in  2*ADDR_W  packed byte addresses; requester 0 in the low slice.
- req_wdata  in  2*DATA_W  packed write data.
- rsp_valid  out  2  one-cycle completion pulse per requester.
- rsp_err  out  1  error flag qualifying rsp_valid.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads.
- mem_addr  out  ADDR_W  to memory Address.
- mem_wdata  out  DATA_W  to memory WriteData.
- mem_write_n  out  1  to MemWrite; 0 = write.
- mem_read_n  out  1  to MemRead; 0 = read, 1 = high-Z.
- mem_rdata  in  DATA_W  from memory DataOut.

Behaviour:
- Reset values:
  - state IDLE; req_ready=0; rsp_valid=0; rsp_err=0; rsp_rdata=0.
  - mem_addr=0; mem_wdata=0; mem_write_n=1; mem_read_n=1; last_grant=1, so requester 0 wins first.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - If any req_valid is set, grant one requester and assert its req_ready combinationally in that cycle (T).
  - Latch addr, wdata, write and requester id at posedge, update last_grant, then go to ACCESS.
  - req_ready is 0 in ACCESS.
- Arbitration:
  - Only one valid requester: grant it.
  - Both valid: grant the one that is not last_grant.
  - Neither valid: stay in IDLE.
- ACCESS (cycle T+1):
  - mem_addr and mem_wdata come from the latched values.
  - Write: mem_write_n=0, mem_read_n=1. The memory commits at negedge inside T+1.
  - Read: mem_read_n=0, mem_write_n=1. mem_rdata is sampled into rsp_rdata at the posedge ending T+1.
  - Always return to IDLE.
- Response:
  - rsp_valid[id]=1 for exactly cycle T+2, for both reads and writes.
  - rsp_rdata holds the last read value until the next read completes; writes leave it unchanged.
- Latency and throughput:
  - Accept-to-response latency is 2 cycles.
  - Peak throughput is one transaction per 2 cycles.
  - A new grant may occur in T+2, overlapping that response.
- Strobes outside ACCESS: mem_write_n=1 and mem_read_n=1, so the memory bus is high-Z.
- Reset during ACCESS:
  - mem_write_n and mem_read_n are forced to 1 combinationally while Reset=1, so no write lands in a reset cycle.
  - The transaction is dropped with no rsp_valid.
- Requesters must hold valid/addr/wdata stable until ready. Dropping valid before ready is legal and cancels the request.
- Address arithmetic: the arbiter passes the address untouched. Byte lanes Address..Address+3 are memory-side, MSB at the lowest address.

Optional Feature:
- Macro: DMEM_ARB_ADDR_CHECK_EN.
- Defined:
  - A granted request with addr[1:0]!=0 or addr>MEM_BYTES-4 performs no memory access; both strobes stay 1 in ACCESS.
  - Its response at T+2 carries rsp_err=1; rsp_rdata is forced to 0 for reads.
- Undefined: no check is performed, rsp_err is tied 0, and all addresses pass through.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding constants ST_IDLE and ST_ACCESS;
  - NUM_REQ=2 and WORD_BYTES=4;
  - the requester id constants REQ_CPU=0 and REQ_DBG=1.
- One sub-module, rr_arb2: combinational 2-way round-robin grant from valid plus last_grant, outputting a one-hot grant.

Test Plan:
- Write then read, requester 0 only:
  - Stimulus: write addr 8, data 0x11223344; then read addr 8.
  - Required: memory bytes 8..11 = 11,22,33,44; rsp_valid[0] at T+2 each time; read rsp_rdata=0x11223344.
- Contention fairness:
  - Stimulus: both requesters hold valid reads continuously for 8 cycles after reset.
  - Required: grants alternate 0,1,0,1; each rsp_valid arrives exactly 2 cycles after its ready.
- Back-to-back:
  - Stimulus: requester 1 issues 4 writes to addrs 0, 4, 8 and 12 with valid held high.
  - Required: ready every 2 cycles; mem_write_n low exactly 4 cycles, each in ACCESS only.
- Reset during ACCESS:
  - Stimulus: assert Reset in the ACCESS cycle of a write of 0xDEADBEEF to addr 16.
  - Required: bytes 16..19 unchanged; no rsp_valid; all outputs at reset values next cycle.
- Idle bus:
  - Stimulus: no requests for 5 cycles.
  - Required: mem_read_n=1, mem_write_n=1, req_ready=0 and rsp_valid=0 throughout.
- With DMEM_ARB_ADDR_CHECK_EN defined:
  - Stimulus: read addr 6, then write addr 60.
  - Required: no strobe asserted; rsp_err=1 and rsp_rdata=0 for both; a subsequent read of addr 4 returns rsp_err=0.
